// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring, one quotient bit per cycle, WIDTH+1 edges.
// Ports: clk, rst, start/op/rs1_val/rs2_val/rd_in in; flush; busy, done, result, rd_out out.
module div_unit #(
  parameter int WIDTH        = 32,
  parameter int ADRESS_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [WIDTH-1:0]        rs1_val,
  input  logic [WIDTH-1:0]        rs2_val,
  input  logic [ADRESS_WIDTH-1:0] rd_in,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic [ADRESS_WIDTH-1:0] rd_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]           cnt;
  logic [1:0]              op_q;
  logic [ADRESS_WIDTH-1:0] rd_q;
  logic [WIDTH-1:0]        rem, quo, dvs, raw;
  logic                    qsign, rsign, dz;

  logic                    sgn_op;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic [WIDTH:0]          shifted, diff;
  logic [WIDTH-1:0]        q_fix, r_fix, res_nx;

  // DIV/REM are the even opcodes
  assign sgn_op = ~op[0];
  assign a_mag  = (sgn_op && rs1_val[WIDTH-1]) ? -rs1_val : rs1_val;
  assign b_mag  = (sgn_op && rs2_val[WIDTH-1]) ? -rs2_val : rs2_val;

  // partial remainder is WIDTH+1 bits only for the trial subtract
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_fix = qsign ? -quo : quo;
  assign r_fix = rsign ? -rem : rem;

  always_comb begin
    res_nx = quo;
    unique case (op_q)
      2'd0:    res_nx = dz ? '1 : q_fix;
      2'd1:    res_nx = dz ? '1 : quo;
      2'd2:    res_nx = dz ? raw : r_fix;
      default: res_nx = dz ? raw : rem;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = CALC;
        CALC:    if (cnt == LAST) state_nx = FIX;
        FIX:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      raw    <= '0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            cnt   <= '0;
            op_q  <= op;
            rd_q  <= rd_in;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            raw   <= rs1_val;
            qsign <= rs1_val[WIDTH-1] ^ rs2_val[WIDTH-1];
            rsign <= rs1_val[WIDTH-1];
            dz    <= (rs2_val == '0);
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!flush) begin
            result <= res_nx;
            rd_out <= rd_q;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Hand-computed vectors: signs, divide by zero, overflow, flush, back-to-back, reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;

  div_unit #(.WIDTH(32), .ADRESS_WIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // skip=1: caller is already at the negedge where start must be driven
  task automatic run(input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input bit skip, input bit poke,
                     output logic [31:0] res, output logic [4:0] rdo,
                     output int lat, output int bcnt);
    bit got;
    if (!skip) @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h0000_0003;
    rd_in = ~rd; op = ~o;
    lat = 0; bcnt = 0; got = 0; res = 'x; rdo = 'x;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (poke && lat == 5) start = 1'b1;
      if (poke && lat == 6) start = 1'b0;
      if (done) begin
        got = 1;
        res = result;
        rdo = rd_out;
      end
    end
  endtask

  logic [31:0] r;
  logic [4:0]  d;
  int          lat, bc, seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; rs1_val = '0;
    rs2_val = '0; rd_in = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", 32'(rd_out), 32'd0);

    run(2'd1, 32'd100, 32'd7, 5'd5, 0, 0, r, d, lat, bc);
    chk("divu_res", r, 32'd14);
    chk("divu_rd", 32'(d), 32'd5);
    chk("divu_lat", 32'(lat), 32'd34);
    chk("divu_busy", 32'(bc), 32'd33);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 32'd0);
    chk("result_held", result, 32'd14);

    run(2'd3, 32'd100, 32'd7, 5'd6, 0, 0, r, d, lat, bc);
    chk("remu_res", r, 32'd2);
    run(2'd0, -32'sd7, 32'd2, 5'd1, 0, 0, r, d, lat, bc);
    chk("div_n7_2", r, 32'hFFFF_FFFD);
    run(2'd2, -32'sd7, 32'd2, 5'd1, 0, 0, r, d, lat, bc);
    chk("rem_n7_2", r, 32'hFFFF_FFFF);
    run(2'd0, 32'd7, -32'sd2, 5'd1, 0, 0, r, d, lat, bc);
    chk("div_7_n2", r, 32'hFFFF_FFFD);
    run(2'd2, 32'd7, -32'sd2, 5'd1, 0, 0, r, d, lat, bc);
    chk("rem_7_n2", r, 32'd1);

    run(2'd0, 32'h1234, 32'd0, 5'd2, 0, 0, r, d, lat, bc);
    chk("dz_div", r, 32'hFFFF_FFFF);
    chk("dz_lat", 32'(lat), 32'd34);
    run(2'd1, 32'h1234, 32'd0, 5'd2, 0, 0, r, d, lat, bc);
    chk("dz_divu", r, 32'hFFFF_FFFF);
    run(2'd2, 32'h1234, 32'd0, 5'd2, 0, 0, r, d, lat, bc);
    chk("dz_rem", r, 32'h1234);
    run(2'd3, 32'h1234, 32'd0, 5'd2, 0, 0, r, d, lat, bc);
    chk("dz_remu", r, 32'h1234);

    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0, 0, r, d, lat, bc);
    chk("ovf_div", r, 32'h8000_0000);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0, 0, r, d, lat, bc);
    chk("ovf_rem", r, 32'd0);

    // start pulsed during busy must not disturb the running op
    run(2'd1, 32'd100, 32'd7, 5'd9, 0, 1, r, d, lat, bc);
    chk("poke_res", r, 32'd14);
    chk("poke_lat", 32'(lat), 32'd34);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("poke_no_extra", 32'(seen), 32'd0);

    // flush in the 10th CALC cycle
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_result", result, 32'd14);
    chk("flush_rd", 32'(rd_out), 32'd9);

    // start and flush together: dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; rs1_val = 32'd9; rs2_val = 32'd3;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("sf_busy", 32'(busy), 32'd0);

    // back-to-back: second start in the done cycle
    run(2'd1, 32'd1000, 32'd10, 5'd4, 0, 0, r, d, lat, bc);
    chk("b2b_first", r, 32'd100);
    run(2'd3, 32'd1000, 32'd33, 5'd8, 1, 0, r, d, lat, bc);
    chk("b2b_second", r, 32'd10);
    chk("b2b_rd", 32'(d), 32'd8);
    chk("b2b_gap", 32'(lat), 32'd34);

    // reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs1_val = 32'd77; rs2_val = 32'd7; rd_in = 5'd11;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit sitting directly downstream of the register file read ports. It captures the two source operands (rs1/rs2 values) and the destination index, runs a one-bit-per-cycle restoring division with a fixed latency, and presents the result, the destination address and a one-cycle write strobe that drive the register file write port (data, address, write enable). The pipeline stalls on `busy` while the unit is computing.

## Interface
- `WIDTH`, 32: operand/result width.
- `ADRESS_WIDTH`, 5: register index width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `rs1_val`  in  WIDTH  dividend (register file read data 0).
- `rs2_val`  in  WIDTH  divisor (register file read data 1).
- `rd_in`  in  ADRESS_WIDTH  destination register index.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle write strobe for the register file write enable.
- `result`  out  WIDTH  quotient or remainder; valid while `done`=1, held afterwards.
- `rd_out`  out  ADRESS_WIDTH  destination index; valid with `done`.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, iteration counter 0..WIDTH-1.
  - FIX: `busy`=1, sign fix-up and result register.
- IDLE -> CALC on `start`=1 and `flush`=0.
  - Latches `op`, `rd_in` and the operand magnitudes.
  - For DIV/REM, a negative operand is replaced by its two's complement, treated as unsigned. |-2^31| = 0x8000_0000.
  - Latches the quotient sign (rs1[31]^rs2[31]) and the remainder sign (rs1[31]).
  - Latches a divide-by-zero flag (rs2==0) and the raw `rs1_val`.
- CALC, one restoring step per cycle on a WIDTH+1-bit partial remainder:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor.
  - Keep the difference and set the quotient LSB if the difference is non-negative.
  - After WIDTH steps, go to FIX.
- FIX:
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Signed ops negate the quotient if the quotient sign is set, and the remainder if the remainder sign is set.
  - Divide by zero overrides: quotient = all ones, remainder = raw `rs1_val`.
  - Register `result` and `rd_out`, pulse `done`, go to IDLE.
- Signed overflow (-2^31 / -1) needs no special case: quotient 0x8000_0000, remainder 0.
- `start` while `busy`=1 is ignored; operand changes after acceptance are ignored.
- `flush`=1 in any state:
  - Next state is IDLE, no `done` is generated, and `result`/`rd_out` are not updated.
  - `flush` and `start` in the same cycle: flush wins and the request is dropped.
- `rd_in`=0 is processed normally; the register file discards writes to x0.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.
- `rst` mid-operation behaves like `flush`, and additionally clears `result` and `rd_out`.
- Acceptance edge E0 (`start`=1 in IDLE):
  - `busy`=1 from the cycle after E0.
  - CALC occupies edges E1..E32; the FIX edge is E33.
  - `done`=1 and `busy`=0 in the cycle after E33.
  - Fixed latency is WIDTH+1 edges, with no early-out for zero or small operands.
- `done` lasts exactly one cycle. `busy`=0 in that cycle, so a new `start` may be accepted in the `done` cycle (back-to-back, 34-cycle issue interval).
- `busy` is registered and never combinationally dependent on `start`.

## Test plan
- DIVU 100 / 7, rd=5, start at E0:
  - `busy` high for 33 cycles.
  - `done` one cycle after E33, with `result`=14 and `rd_out`=5.
  - REMU on the same operands gives 2.
- Signed sign combinations:
  - DIV -7/2 gives 0xFFFF_FFFD (-3).
  - REM -7/2 gives 0xFFFF_FFFF (-1).
  - DIV 7/-2 gives -3.
  - REM 7/-2 gives 1.
- Divide by zero, rs1=0x1234, rs2=0:
  - DIV and DIVU give 0xFFFF_FFFF.
  - REM and REMU give 0x1234.
  - Latency is still 33 edges.
- Overflow, rs1=0x8000_0000, rs2=0xFFFF_FFFF:
  - DIV gives 0x8000_0000.
  - REM gives 0.
- Flush and drop behaviour:
  - `flush` at cycle 10 of CALC: `busy` drops next cycle, no `done`, `result` keeps its prior value.
  - `start`+`flush` in the same cycle: no operation is started.
- Back-to-back and reset:
  - `start` asserted in the `done` cycle: second operation accepted, second `done` 34 cycles after the first.
  - `start` during `busy`: ignored.
  - `rst` mid-CALC: all outputs 0 next cycle.
